// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
package serial_add_sequencer_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Request/result bundle between a control unit (master) and the sequencer (slave).
interface serial_add_sequencer_if #(
    parameter int N = serial_add_sequencer_pkg::DEFAULT_N
);
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sequencer_fa.sv
// The shared 1-bit full-adder cell that the sequencer time-multiplexes.
module serial_add_sequencer_fa (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_add_sequencer.sv
// N-bit add/subtract computed LSB-first through one full-adder cell, one bit per clock.
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_sequencer_if.slave req_if
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [N-1:0]  a_sh_q,  a_sh_d;
    logic [N-1:0]  b_sh_q,  b_sh_d;
    logic [N-1:0]  res_q,   res_d;
    logic          c_q,     c_d;
    logic          cmsb_q,  cmsb_d;
    logic          cout_q,  cout_d;
    logic          ovf_q,   ovf_d;

    logic          fa_s;
    logic          fa_co;

    serial_add_sequencer_fa u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (c_q),
        .S    (fa_s),
        .Cout (fa_co)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        c_d     = c_q;
        cmsb_d  = cmsb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (req_if.start) begin
                    // Subtract is A + ~B + 1: invert B here, the +1 enters as the initial carry.
                    a_sh_d  = req_if.a;
                    b_sh_d  = req_if.sub ? ~req_if.b : req_if.b;
                    c_d     = req_if.sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {fa_s, res_q[N-1:1]};
                c_d    = fa_co;
                if (cnt_q == CW'(N - 2)) begin
                    cmsb_d = fa_co;
                end
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = fa_co;
                    ovf_d   = cmsb_q ^ fa_co;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cmsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cmsb_q  <= cmsb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status flags are pure decodes of the state register, so no input reaches an output.
    assign req_if.busy = (state_q == ST_RUN);
    assign req_if.done = (state_q == ST_DONE);
    assign req_if.sum  = res_q;
    assign req_if.cout = cout_q;
    assign req_if.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench: N=8 directed/random/reset/held-start tests and an exhaustive N=4 sweep.
module tb_serial_add_sequencer;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk  = 1'b0;
    logic rst8 = 1'b1;
    logic rst4 = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc8   = 0;

    exp_t q8[$];
    exp_t q4[$];
    int   done_cyc8[$];

    always #5 clk = ~clk;

    serial_add_sequencer_if #(.N(8)) if8 ();
    serial_add_sequencer_if #(.N(4)) if4 ();

    serial_add_sequencer #(.N(8)) dut8 (.clk(clk), .rst(rst8), .req_if(if8));
    serial_add_sequencer #(.N(4)) dut4 (.clk(clk), .rst(rst4), .req_if(if4));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain modulo arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input int n, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub);
        exp_t   e;
        longint one  = 1;
        longint mask = (one << n) - 1;
        longint ua   = longint'(a) & mask;
        longint ub   = longint'(b) & mask;
        longint sa   = (ua >= (one << (n - 1))) ? ua - (one << n) : ua;
        longint sb   = (ub >= (one << (n - 1))) ? ub - (one << n) : ub;
        longint full = sub ? ua - ub : ua + ub;
        longint sres = sub ? sa - sb : sa + sb;
        e.sum  = 32'(full & mask);
        e.cout = sub ? (ua >= ub) : (full > mask);
        e.ovf  = (sres > (one << (n - 1)) - 1) || (sres < -(one << (n - 1)));
        return e;
    endfunction

    // Monitors: pop one expectation per done pulse; also watch busy/done exclusivity.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc8++;
            check("busy_done_excl8", 32'(if8.busy & if8.done), 32'd0);
            if (if8.done) begin
                done_cyc8.push_back(cyc8);
                if (q8.size() == 0) begin
                    check("unexpected_done8", 32'd1, 32'd0);
                end else begin
                    e = q8.pop_front();
                    check("sum8",  32'(if8.sum),  e.sum);
                    check("cout8", 32'(if8.cout), 32'(e.cout));
                    check("ovf8",  32'(if8.ovf),  32'(e.ovf));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if4.done) begin
                if (q4.size() == 0) begin
                    check("unexpected_done4", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    check("sum4",  32'(if4.sum),  e.sum);
                    check("cout4", 32'(if4.cout), 32'(e.cout));
                    check("ovf4",  32'(if4.ovf),  32'(e.ovf));
                end
            end
        end
    end

    task automatic wait_idle8();
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!if8.busy && !if8.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout8", 32'd0, 32'd1);
    endtask

    task automatic wait_idle4();
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!if4.busy && !if4.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout4", 32'd0, 32'd1);
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int lat = 0;
        wait_idle8();
        if8.a     = a;
        if8.b     = b;
        if8.sub   = sub;
        if8.start = 1'b1;
        q8.push_back(model(8, 32'(a), 32'(b), sub));
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        check("busy_after_start", 32'(if8.busy), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (if8.done) begin
                lat = k;
                break;
            end
        end
        check("done_edge", 32'(lat), 32'd8);
    endtask

    task automatic check_zero8(input string tag);
        check({tag, "_busy"}, 32'(if8.busy), 32'd0);
        check({tag, "_done"}, 32'(if8.done), 32'd0);
        check({tag, "_sum"},  32'(if8.sum),  32'd0);
        check({tag, "_cout"}, 32'(if8.cout), 32'd0);
        check({tag, "_ovf"},  32'(if8.ovf),  32'd0);
    endtask

    task automatic tests8();
        // Reset state.
        #3;
        check_zero8("reset");
        @(negedge clk);
        rst8 = 1'b0;

        go8(8'h3C, 8'h5A, 1'b0);
        go8(8'hFF, 8'h01, 1'b0);
        go8(8'h7F, 8'h01, 1'b0);
        go8(8'h10, 8'h20, 1'b1);
        go8(8'h80, 8'h01, 1'b1);
        go8(8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            go8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Start held high with operands changing every cycle: only accepted ones count.
        wait_idle8();
        done_cyc8.delete();
        for (int e = 0; e < 3 * 10; e++) begin
            if8.a     = 8'($urandom);
            if8.b     = 8'($urandom);
            if8.sub   = 1'($urandom);
            if8.start = 1'b1;
            if (e % 10 == 0) q8.push_back(model(8, 32'(if8.a), 32'(if8.b), if8.sub));
            @(posedge clk);
            #1;
        end
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        check("held_done_count", 32'(done_cyc8.size()), 32'd3);
        if (done_cyc8.size() == 3) begin
            check("done_spacing_1", 32'(done_cyc8[1] - done_cyc8[0]), 32'd10);
            check("done_spacing_2", 32'(done_cyc8[2] - done_cyc8[1]), 32'd10);
        end

        // Asynchronous reset between edges 4 and 5 of a run; that operation must vanish.
        wait_idle8();
        if8.a     = 8'hFF;
        if8.b     = 8'h7F;
        if8.sub   = 1'b0;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst8 = 1'b1;
        #1;
        check_zero8("midrun_reset");
        @(negedge clk);
        rst8 = 1'b0;
        go8(8'h01, 8'h02, 1'b0);
    endtask

    task automatic sweep4();
        @(negedge clk);
        rst4 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    wait_idle4();
                    if4.a     = 4'(a);
                    if4.b     = 4'(b);
                    if4.sub   = 1'(s);
                    if4.start = 1'b1;
                    q4.push_back(model(4, 32'(a), 32'(b), 1'(s)));
                    @(posedge clk);
                    #1;
                    if4.start = 1'b0;
                end
            end
        end
    endtask

    initial begin
        if8.start = 1'b0; if8.sub = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.sub = 1'b0; if4.a = '0; if4.b = '0;
        fork
            tests8();
            sweep4();
        join
        repeat (20) @(negedge clk);
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
